jimbo_bus_arbiter: RTL and testbench
====================================

# jimbo_bus_arbiter

Shares the single external nibble memory bus of the Jimbo chip between two requesters: the CPU core (master 0) and a serial program loader/debug port (master 1). Arbitrates with round-robin fairness, sequences each access through a fixed-length bus cycle with configurable wait states, and returns read data with a one-cycle acknowledge. Sits between the requesters and the top-level pads: `bus_addr` on `uo_out`/`uio_out[7:4]`, nibble data on `uio[3:0]`, with `bus_data_rw` driving the data output enables.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles the address is held before read data is sampled; legal range 0..7.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `m0_req`, `m1_req`  input  1 each  access request; held high until the matching ack.
- `m0_we`, `m1_we`  input  1 each  1 = write, 0 = read; stable while req is high.
- `m0_addr`, `m1_addr`  input  12 each  access address; stable while req is high.
- `m0_wdata`, `m1_wdata`  input  4 each  write nibble; stable while req is high.
- `m0_rdata`, `m1_rdata`  output  4 each  read nibble; valid in the ack cycle, held until the next ack to that master.
- `m0_ack`, `m1_ack`  output  1 each  one-cycle completion pulse.
- `bus_addr`  output  12  external address.
- `bus_data_out`  output  4  external write nibble.
- `bus_data_in`  input  4  external read nibble.
- `bus_data_rw`  output  1  1 = write cycle, drive data pins; 0 = pins are inputs.

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: sample both `req`. If neither is high, stay. If exactly one is high, grant it. If both are high, grant the master not granted last (`last_grant` register). On grant, register the addr, we and wdata of the winner, set `grant_id`, clear `wait_cnt`, and go to ACCESS.
- ACCESS: `bus_addr` = latched addr. `bus_data_rw` = latched we. `bus_data_out` = latched wdata on a write; on a read it holds its previous value.
  - The state lasts exactly `WAIT_CYCLES`+1 cycles; `wait_cnt` (3 bits) increments each cycle.
  - On the final ACCESS edge of a read: capture `bus_data_in` into the granted master's rdata register.
  - On the final ACCESS edge of any access: go to ACK and update `last_grant` to `grant_id`.
- ACK: assert the granted master's ack for one cycle. `bus_data_rw` = 0. Next state is IDLE unconditionally.
  - A req still high in the cycle after ack is treated as a new request.
- `bus_addr` holds its last value outside ACCESS; no glitching to 0 between accesses.
- Only the granted master's ack and rdata change; the other master's outputs are untouched.

## Timing
- Reset values (at the edge sampling `rst_n`=0):
  - state = IDLE, `bus_addr` = 0x000, `bus_data_out` = 0x0, `bus_data_rw` = 0.
  - Both ack = 0, both rdata = 0x0.
  - `last_grant` = 1, so master 0 (CPU) wins the first contention.
- Latency: req seen high in IDLE at edge E.
  - Bus signals are valid from E to E+WAIT_CYCLES+1.
  - Ack is high from E+WAIT_CYCLES+1 to E+WAIT_CYCLES+2.
  - Back in IDLE at E+WAIT_CYCLES+2.
  - Back-to-back period is `WAIT_CYCLES`+3 cycles (4 cycles at the default).
- Read data is sampled on the same edge that leaves ACCESS. External memory must present data within `WAIT_CYCLES`+1 cycles of the address.
- `bus_data_rw` is high only during ACCESS of a write; it is low in IDLE and ACK.
- Reset mid-access (ACCESS or ACK):
  - Abort immediately; all outputs take their reset values on that edge.
  - No ack is issued and the write is not completed further.
  - Masters must re-request after reset.
- A req deasserted during ACCESS (protocol violation): the access still completes and the ack is still issued.
- Both req rising in the same cycle: exactly one grant, chosen per `last_grant`; never both acks in one cycle.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with both req high -> `bus_addr`=0x000, `bus_data_rw`=0, both ack=0. On release, master 0 is granted first.
- Single read, `WAIT_CYCLES`=1: m0 reads 0xABC while the bench drives `bus_data_in`=0x5 -> `bus_addr`=0xABC for 2 cycles with `bus_data_rw`=0, then `m0_ack` for 1 cycle with `m0_rdata`=0x5.
- Single write: m1 writes 0x9 to 0x123 -> `bus_addr`=0x123, `bus_data_out`=0x9, `bus_data_rw`=1 for exactly 2 cycles, then `m1_ack` pulses with `bus_data_rw`=0.
- Contention: both masters hold req for 4 accesses each -> grants alternate m0, m1, m0, m1…; each access is 4 cycles; no double ack.
- Wait-state sweep: `WAIT_CYCLES`=0 and 7 -> ack at exactly 1 and 8 cycles after the grant edge; `bus_data_in` changed one cycle before the sample edge is captured.
- Reset mid-write: assert `rst_n`=0 in the second ACCESS cycle -> `bus_data_rw`=0 on the next edge, no `m1_ack`, and the arbiter is in IDLE after release.

Source files
------------

// File: rtl/jimbo_bus_arbiter_if.sv
// Requester and external-bus signals of the Jimbo nibble-bus arbiter.
// The arbiter takes the slave view; requesters and pad logic take the master view.
interface jimbo_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [11:0] m0_addr;
    logic [3:0]  m0_wdata;
    logic [3:0]  m0_rdata;
    logic        m0_ack;

    logic        m1_req;
    logic        m1_we;
    logic [11:0] m1_addr;
    logic [3:0]  m1_wdata;
    logic [3:0]  m1_rdata;
    logic        m1_ack;

    logic [11:0] bus_addr;
    logic [3:0]  bus_data_out;
    logic [3:0]  bus_data_in;
    logic        bus_data_rw;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_data_in,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output bus_addr, bus_data_out, bus_data_rw
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_data_in,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  bus_addr, bus_data_out, bus_data_rw
    );
endinterface

// File: rtl/jimbo_bus_arbiter.sv
// Round-robin arbiter sharing the external nibble bus between CPU (m0) and loader (m1).
// Each access: grant edge, WAIT_CYCLES+1 ACCESS cycles, one ACK cycle; requesters stall by holding req.
module jimbo_bus_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    jimbo_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic        grant_id;
    logic        last_grant;
    logic        lat_we;
    logic [2:0]  wait_cnt;

    logic        any_req;
    logic        pick;
    logic        last_cycle;
    logic [11:0] win_addr;
    logic        win_we;
    logic [3:0]  win_wdata;

    assign any_req    = bus.m0_req | bus.m1_req;
    // m1 wins when it is alone, or when both ask and m0 was served last
    assign pick       = bus.m1_req & (~bus.m0_req | ~last_grant);
    assign last_cycle = (wait_cnt == WAIT_LAST);
    assign win_addr   = pick ? bus.m1_addr  : bus.m0_addr;
    assign win_we     = pick ? bus.m1_we    : bus.m0_we;
    assign win_wdata  = pick ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (last_cycle) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bus_addr doubles as the latched address, so it holds between accesses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_id         <= 1'b0;
            last_grant       <= 1'b1;
            lat_we           <= 1'b0;
            wait_cnt         <= 3'd0;
            bus.bus_addr     <= 12'h000;
            bus.bus_data_out <= 4'h0;
            bus.m0_rdata     <= 4'h0;
            bus.m1_rdata     <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id     <= pick;
                        lat_we       <= win_we;
                        wait_cnt     <= 3'd0;
                        bus.bus_addr <= win_addr;
                        if (win_we) bus.bus_data_out <= win_wdata;
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (last_cycle) begin
                        last_grant <= grant_id;
                        if (!lat_we) begin
                            if (grant_id) bus.m1_rdata <= bus.bus_data_in;
                            else          bus.m0_rdata <= bus.bus_data_in;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_data_rw = (state == ACCESS) & lat_we;
    assign bus.m0_ack      = (state == ACK) & ~grant_id;
    assign bus.m1_ack      = (state == ACK) &  grant_id;
endmodule

// File: tb/tb_jimbo_bus_arbiter.sv
// Directed bench for jimbo_bus_arbiter: default wait states plus 0 and 7 wait-state instances.
module tb_jimbo_bus_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    jimbo_bus_arbiter_if ifa();
    jimbo_bus_arbiter_if ifb();
    jimbo_bus_arbiter_if ifc();

    jimbo_bus_arbiter #(.WAIT_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    jimbo_bus_arbiter #(.WAIT_CYCLES(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    jimbo_bus_arbiter #(.WAIT_CYCLES(7)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_ack;
        logic exp_id;
        checks = 0;
        errors = 0;

        ifa.m0_req = 1'b1; ifa.m0_we = 1'b0; ifa.m0_addr = 12'hABC; ifa.m0_wdata = 4'h0;
        ifa.m1_req = 1'b1; ifa.m1_we = 1'b1; ifa.m1_addr = 12'h123; ifa.m1_wdata = 4'h9;
        ifa.bus_data_in = 4'h5;
        ifb.m0_req = 1'b0; ifb.m0_we = 1'b0; ifb.m0_addr = 12'h0F0; ifb.m0_wdata = 4'h0;
        ifb.m1_req = 1'b0; ifb.m1_we = 1'b0; ifb.m1_addr = 12'h000; ifb.m1_wdata = 4'h0;
        ifb.bus_data_in = 4'h3;
        ifc.m0_req = 1'b0; ifc.m0_we = 1'b0; ifc.m0_addr = 12'h0F0; ifc.m0_wdata = 4'h0;
        ifc.m1_req = 1'b0; ifc.m1_we = 1'b0; ifc.m1_addr = 12'h000; ifc.m1_wdata = 4'h0;
        ifc.bus_data_in = 4'h2;
        rst_n = 1'b0;

        // Reset held two cycles with both requests high
        step();
        step();
        check("rst_addr",   16'(ifa.bus_addr), 16'h000);
        check("rst_rw",     16'(ifa.bus_data_rw), 16'h0);
        check("rst_dout",   16'(ifa.bus_data_out), 16'h0);
        check("rst_ack0",   16'(ifa.m0_ack), 16'h0);
        check("rst_ack1",   16'(ifa.m1_ack), 16'h0);
        check("rst_rdata0", 16'(ifa.m0_rdata), 16'h0);
        check("rst_rdata1", 16'(ifa.m1_rdata), 16'h0);
        rst_n = 1'b1;

        // m0 wins first contention, read 0xABC
        step();
        check("rd_addr_c0", 16'(ifa.bus_addr), 16'hABC);
        check("rd_rw_c0",   16'(ifa.bus_data_rw), 16'h0);
        check("rd_ack_c0",  16'(ifa.m0_ack), 16'h0);
        step();
        check("rd_addr_c1", 16'(ifa.bus_addr), 16'hABC);
        check("rd_ack_c1",  16'(ifa.m0_ack), 16'h0);
        step();
        check("rd_ack0",    16'(ifa.m0_ack), 16'h1);
        check("rd_ack1",    16'(ifa.m1_ack), 16'h0);
        check("rd_rdata",   16'(ifa.m0_rdata), 16'h5);
        check("rd_rw_ack",  16'(ifa.bus_data_rw), 16'h0);
        ifa.m0_req = 1'b0;
        step();
        check("rd_ack_gone", 16'(ifa.m0_ack), 16'h0);
        check("addr_hold",   16'(ifa.bus_addr), 16'hABC);

        // m1 write 0x9 to 0x123
        step();
        check("wr_addr_c0", 16'(ifa.bus_addr), 16'h123);
        check("wr_dout_c0", 16'(ifa.bus_data_out), 16'h9);
        check("wr_rw_c0",   16'(ifa.bus_data_rw), 16'h1);
        step();
        check("wr_rw_c1",   16'(ifa.bus_data_rw), 16'h1);
        check("wr_ack_c1",  16'(ifa.m1_ack), 16'h0);
        step();
        check("wr_ack1",    16'(ifa.m1_ack), 16'h1);
        check("wr_ack0",    16'(ifa.m0_ack), 16'h0);
        check("wr_rw_ack",  16'(ifa.bus_data_rw), 16'h0);
        check("wr_rdata1",  16'(ifa.m1_rdata), 16'h0);
        check("wr_rdata0",  16'(ifa.m0_rdata), 16'h5);
        ifa.m1_req = 1'b0;
        step();
        check("wr_idle_ack", 16'(ifa.m1_ack), 16'h0);
        check("wr_idle_addr", 16'(ifa.bus_addr), 16'h123);

        // Contention: both hold req for 8 accesses, m0 served first
        ifa.m0_addr = 12'h200; ifa.m0_we = 1'b0;
        ifa.m1_addr = 12'h300; ifa.m1_we = 1'b1; ifa.m1_wdata = 4'hC;
        ifa.bus_data_in = 4'h7;
        ifa.m0_req = 1'b1; ifa.m1_req = 1'b1;
        n_ack = 0;
        exp_id = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            step();
            check("no_double_ack", 16'(ifa.m0_ack & ifa.m1_ack), 16'h0);
            if (ifa.m0_ack || ifa.m1_ack) begin
                check("rr_order", 16'(ifa.m1_ack), 16'(exp_id));
                check("rr_period", 16'(c), 16'(3 + 4 * n_ack));
                check("rr_addr", 16'(ifa.bus_addr), exp_id ? 16'h300 : 16'h200);
                if (ifa.m0_ack) check("rr_rdata0", 16'(ifa.m0_rdata), 16'h7);
                n_ack++;
                exp_id = ~exp_id;
            end
        end
        check("rr_count", 16'(n_ack), 16'd8);
        ifa.m0_req = 1'b0; ifa.m1_req = 1'b0;
        step();

        // req dropped during ACCESS: access still completes
        ifa.m0_addr = 12'h0AA; ifa.bus_data_in = 4'h4; ifa.m0_req = 1'b1;
        step();
        ifa.m0_req = 1'b0;
        step();
        step();
        check("drop_ack",   16'(ifa.m0_ack), 16'h1);
        check("drop_rdata", 16'(ifa.m0_rdata), 16'h4);
        step();

        // Reset during the second ACCESS cycle of an m1 write
        ifa.m1_addr = 12'h456; ifa.m1_wdata = 4'h9; ifa.m1_we = 1'b1; ifa.m1_req = 1'b1;
        step();
        check("mr_rw_c0", 16'(ifa.bus_data_rw), 16'h1);
        step();
        rst_n = 1'b0;
        step();
        check("mr_rw",   16'(ifa.bus_data_rw), 16'h0);
        check("mr_ack1", 16'(ifa.m1_ack), 16'h0);
        check("mr_addr", 16'(ifa.bus_addr), 16'h000);
        check("mr_dout", 16'(ifa.bus_data_out), 16'h0);
        rst_n = 1'b1;
        ifa.m1_req = 1'b0;
        step();
        check("mr_noack", 16'(ifa.m1_ack), 16'h0);
        check("mr_rw_post", 16'(ifa.bus_data_rw), 16'h0);
        ifa.m0_addr = 12'h0AB; ifa.m0_req = 1'b1;
        step();
        check("mr_idle_grant", 16'(ifa.bus_addr), 16'h0AB);
        step();
        step();
        check("mr_next_ack", 16'(ifa.m0_ack), 16'h1);
        ifa.m0_req = 1'b0;
        step();

        // Wait-state sweep: WAIT_CYCLES=0 (dut_b) and 7 (dut_c)
        ifb.m0_req = 1'b1;
        ifc.m0_req = 1'b1;
        step();
        check("w0_ack_grant", 16'(ifb.m0_ack), 16'h0);
        check("w0_addr", 16'(ifb.bus_addr), 16'h0F0);
        check("w7_ack_grant", 16'(ifc.m0_ack), 16'h0);
        ifb.bus_data_in = 4'hD;
        step();
        check("w0_ack", 16'(ifb.m0_ack), 16'h1);
        check("w0_rdata", 16'(ifb.m0_rdata), 16'hD);
        check("w7_ack_e1", 16'(ifc.m0_ack), 16'h0);
        ifb.m0_req = 1'b0;
        for (int i = 2; i <= 7; i++) begin
            step();
            check("w7_ack_early", 16'(ifc.m0_ack), 16'h0);
        end
        ifc.bus_data_in = 4'hE;
        step();
        check("w7_ack", 16'(ifc.m0_ack), 16'h1);
        check("w7_rdata", 16'(ifc.m0_rdata), 16'hE);
        check("w0_ack_once", 16'(ifb.m0_ack), 16'h0);
        ifc.m0_req = 1'b0;
        step();
        check("w7_ack_gone", 16'(ifc.m0_ack), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
